// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hazard busy bits, zero register, optional bypass and a sweep-clear engine.
// Reads are combinational; writes and reservations land on the rising edge and are dropped while a sweep runs.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rbusy_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rbusy_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wr_ok;
  logic rsv_ok;
  logic byp_on;

  assign ready    = (state == IDLE);
  assign clr_busy = (state == SWEEP);

  assign wr_ok  = we && ready && !((ZERO_REG != 0) && (waddr == '0));
  assign rsv_ok = rsv_en && ready && !((ZERO_REG != 0) && (rsv_addr == '0));
  assign byp_on = (BYPASS != 0) && we && ready;

  // Returns {busy, data} for one read port; both ports share this priority.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      res = '0;
    end else if (byp_on && (waddr == addr)) begin
      res = {1'b0, wdata};
    end else begin
      res = {busy[addr], regs[addr]};
    end
    return res;
  endfunction

  always_comb begin
    {rbusy_a, rdata_a} = read_port(raddr_a);
    {rbusy_b, rdata_b} = read_port(raddr_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok) begin
            regs[waddr] <= wdata;
            busy[waddr] <= 1'b0;
          end
          // Placed after the write so a same-address reserve leaves the bit set.
          if (rsv_ok) begin
            busy[rsv_addr] <= 1'b1;
          end
          if (clr_req) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
        SWEEP: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default config, ZERO_REG=0 and a narrow BYPASS=0 instance.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance (ZERO_REG=1, BYPASS=1) and ZERO_REG=0 twin share inputs
  logic        we, rsv_en, clr_req;
  logic [3:0]  waddr, rsv_addr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b, nz_rdata_a, nz_rdata_b;
  logic        rbusy_a, rbusy_b, clr_busy, ready;
  logic        nz_rbusy_a, nz_rbusy_b, nz_clr_busy, nz_ready;

  // narrow instance: DATA_W=16, ADDR_W=3, BYPASS=0
  logic        nb_we, nb_rsv_en, nb_clr_req;
  logic [2:0]  nb_waddr, nb_rsv_addr, nb_raddr_a, nb_raddr_b;
  logic [15:0] nb_wdata, nb_rdata_a, nb_rdata_b;
  logic        nb_rbusy_a, nb_rbusy_b, nb_clr_busy, nb_ready;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b),
    .clr_req(clr_req), .clr_busy(clr_busy), .ready(ready)
  );

  regfile_scoreboard #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr_a(raddr_a), .rdata_a(nz_rdata_a), .rbusy_a(nz_rbusy_a),
    .raddr_b(raddr_b), .rdata_b(nz_rdata_b), .rbusy_b(nz_rbusy_b),
    .clr_req(clr_req), .clr_busy(nz_clr_busy), .ready(nz_ready)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata),
    .rsv_en(nb_rsv_en), .rsv_addr(nb_rsv_addr),
    .raddr_a(nb_raddr_a), .rdata_a(nb_rdata_a), .rbusy_a(nb_rbusy_a),
    .raddr_b(nb_raddr_b), .rdata_b(nb_rdata_b), .rbusy_b(nb_rbusy_b),
    .clr_req(nb_clr_req), .clr_busy(nb_clr_busy), .ready(nb_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled near the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    we = 0; rsv_en = 0; clr_req = 0;
    waddr = 0; rsv_addr = 0; raddr_a = 4'd5; raddr_b = 4'd3; wdata = 0;
    nb_we = 0; nb_rsv_en = 0; nb_clr_req = 0;
    nb_waddr = 0; nb_rsv_addr = 0; nb_raddr_a = 0; nb_raddr_b = 0; nb_wdata = 0;

    // reset state
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rbusy_a", {31'd0, rbusy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: write r5 with same-cycle read through the bypass
    we = 1; waddr = 4'd5; wdata = 32'hDEADBEEF; raddr_a = 4'd5;
    #1;
    chk("t1_bypass", rdata_a, 32'hDEADBEEF);
    chk("t1_bypass_busy", {31'd0, rbusy_a}, 32'd0);
    cyc();
    we = 0;
    #1;
    chk("t1_held", rdata_a, 32'hDEADBEEF);
    chk("t1_held_busy", {31'd0, rbusy_a}, 32'd0);

    // 2: zero register ignores write and reserve; ZERO_REG=0 twin keeps both
    we = 1; waddr = 4'd0; wdata = 32'h12345678; rsv_en = 1; rsv_addr = 4'd0; raddr_a = 4'd0;
    #1;
    chk("t2_r0_wcyc", rdata_a, 32'd0);
    chk("t2_nz_bypass", nz_rdata_a, 32'h12345678);
    cyc();
    we = 0; rsv_en = 0;
    #1;
    chk("t2_r0_data", rdata_a, 32'd0);
    chk("t2_r0_busy", {31'd0, rbusy_a}, 32'd0);
    chk("t2_nz_data", nz_rdata_a, 32'h12345678);
    chk("t2_nz_busy", {31'd0, nz_rbusy_a}, 32'd1);

    // 3: reserve r3, then write it, then write+reserve together
    rsv_en = 1; rsv_addr = 4'd3; raddr_b = 4'd3;
    #1;
    chk("t3_busy_before", {31'd0, rbusy_b}, 32'd0);
    cyc();
    rsv_en = 0;
    #1;
    chk("t3_busy_set", {31'd0, rbusy_b}, 32'd1);
    we = 1; waddr = 4'd3; wdata = 32'h55;
    #1;
    chk("t3_wcyc_busy", {31'd0, rbusy_b}, 32'd0);
    chk("t3_wcyc_data", rdata_b, 32'h55);
    cyc();
    we = 0;
    #1;
    chk("t3_after_busy", {31'd0, rbusy_b}, 32'd0);
    chk("t3_after_data", rdata_b, 32'h55);
    we = 1; waddr = 4'd3; wdata = 32'h66; rsv_en = 1; rsv_addr = 4'd3;
    cyc();
    we = 1; waddr = 4'd4; wdata = 32'h44; rsv_en = 1; rsv_addr = 4'd6;
    #1;
    chk("t3_same_busy", {31'd0, rbusy_b}, 32'd1);
    chk("t3_same_data", rdata_b, 32'h66);
    cyc();
    we = 0; rsv_en = 0; raddr_a = 4'd4; raddr_b = 4'd6;
    #1;
    chk("t3_diff_data", rdata_a, 32'h44);
    chk("t3_diff_busy", {31'd0, rbusy_b}, 32'd1);

    // 4: fill everything busy, then sweep
    for (int i = 0; i < 16; i++) begin
      we = 1; waddr = 4'(i); wdata = 32'h100 + 32'(i);
      rsv_en = 1; rsv_addr = 4'(i);
      cyc();
    end
    we = 0; rsv_en = 0; raddr_a = 4'd7; raddr_b = 4'd7;
    #1;
    chk("t4_fill_r7", rdata_a, 32'h107);
    chk("t4_fill_r7_busy", {31'd0, rbusy_b}, 32'd1);
    clr_req = 1;
    cyc();
    clr_req = 0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk($sformatf("t4_clr_busy_%0d", c), {31'd0, clr_busy}, 32'd1);
      chk($sformatf("t4_ready_%0d", c), {31'd0, ready}, 32'd0);
      chk($sformatf("t4_r7_%0d", c), rdata_a, (c <= 8) ? 32'h107 : 32'd0);
      cyc();
    end
    #1;
    chk("t4_done_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("t4_done_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(i);
      #1;
      chk($sformatf("t4_zero_r%0d", i), rdata_a, 32'd0);
      chk($sformatf("t4_idle_r%0d", i), {31'd0, rbusy_b}, 32'd0);
    end

    // 5: write during sweep is dropped (issued after r9 already cleared)
    @(negedge clk);
    clr_req = 1;
    cyc();
    clr_req = 0; raddr_a = 4'd9;
    for (int c = 1; c <= 16; c++) begin
      if (c == 12) begin
        we = 1; waddr = 4'd9; wdata = 32'hAA;
        #1;
        chk("t5_no_bypass", rdata_a, 32'd0);
      end else begin
        we = 0;
      end
      cyc();
    end
    we = 0;
    #1;
    chk("t5_r9_dropped", rdata_a, 32'd0);
    chk("t5_ready_back", {31'd0, ready}, 32'd1);

    // 5b: reset in sweep cycle 5
    we = 1; waddr = 4'd14; wdata = 32'hEE; rsv_en = 1; rsv_addr = 4'd13;
    cyc();
    we = 0; rsv_en = 0; clr_req = 1; raddr_a = 4'd14; raddr_b = 4'd13;
    cyc();
    clr_req = 0;
    for (int c = 1; c < 5; c++) cyc();
    #1;
    chk("t5_mid_clr_busy", {31'd0, clr_busy}, 32'd1);
    chk("t5_mid_r14", rdata_a, 32'hEE);
    rst = 1;
    #1;
    chk("t5_rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("t5_rst_ready", {31'd0, ready}, 32'd1);
    chk("t5_rst_r14", rdata_a, 32'd0);
    chk("t5_rst_busy13", {31'd0, rbusy_b}, 32'd0);
    cyc();
    rst = 0;

    // 6: narrow instance without bypass
    nb_we = 1; nb_waddr = 3'd2; nb_wdata = 16'hBEEF; nb_raddr_a = 3'd2;
    #1;
    chk("t6_old_value", {16'd0, nb_rdata_a}, 32'd0);
    cyc();
    nb_we = 0;
    #1;
    chk("t6_new_value", {16'd0, nb_rdata_a}, 32'hBEEF);
    for (int i = 1; i < 8; i++) begin
      nb_we = 1; nb_waddr = 3'(i); nb_wdata = 16'h1000 + 16'(i);
      nb_rsv_en = 1; nb_rsv_addr = 3'(i);
      cyc();
    end
    nb_we = 0; nb_rsv_en = 0; nb_raddr_a = 3'd7; nb_raddr_b = 3'd7;
    #1;
    chk("t6_fill_r7", {16'd0, nb_rdata_a}, 32'h1007);
    chk("t6_fill_busy7", {31'd0, nb_rbusy_b}, 32'd1);
    nb_clr_req = 1;
    cyc();
    nb_clr_req = 0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("t6_clr_busy_%0d", c), {31'd0, nb_clr_busy}, 32'd1);
      cyc();
    end
    #1;
    chk("t6_ready_back", {31'd0, nb_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      nb_raddr_a = 3'(i); nb_raddr_b = 3'(i);
      #1;
      chk($sformatf("t6_zero_r%0d", i), {16'd0, nb_rdata_a}, 32'd0);
      chk($sformatf("t6_idle_r%0d", i), {31'd0, nb_rbusy_b}, 32'd0);
    end
    // clr_req in the cycle ready returns starts another sweep
    nb_clr_req = 1;
    cyc();
    nb_clr_req = 0;
    #1;
    chk("t6_resweep", {31'd0, nb_clr_busy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the core_lapido pipeline, next generation of the 16x32 register bank.
- Provides configurable width and depth, two combinational read ports and one write port.
- Adds an optional hardwired zero register, optional write-to-read bypass, per-register busy (scoreboard) bits for hazard detection, and a sequential sweep-clear engine.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
we  in  1  write enable (writeback)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
rsv_en  in  1  reserve request: mark rsv_addr busy (issue)
rsv_addr  in  ADDR_W  register to reserve
raddr_a  in  ADDR_W  read port A address
rdata_a  out  DATA_W  read port A data
rbusy_a  out  1  read port A busy flag
raddr_b  in  ADDR_W  read port B address
rdata_b  out  DATA_W  read port B data
rbusy_b  out  1  read port B busy flag
clr_req  in  1  start sweep-clear of all registers
clr_busy  out  1  sweep in progress
ready  out  1  write/reserve accepted this cycle

Behaviour:
- Reset (async, rst=1):
  - All DEPTH registers = 0; all busy bits = 0.
  - FSM = IDLE, sweep counter = 0.
  - ready = 1, clr_busy = 0.
  - Read outputs follow the cleared array: rdata = 0, rbusy = 0.
- ready = (state == IDLE), combinational.
- Write, at posedge when we && ready:
  - regs[waddr] <= wdata; busy[waddr] <= 0.
  - Suppressed entirely when ZERO_REG=1 and waddr == 0.
- Reserve, at posedge when rsv_en && ready:
  - busy[rsv_addr] <= 1.
  - Suppressed when ZERO_REG=1 and rsv_addr == 0.
- Write and reserve to the same address in the same cycle: data is written, busy ends 1 (reserve wins).
- Write and reserve to different addresses in the same cycle: both take effect.
- Read ports A and B, combinational and identical:
  - ZERO_REG=1 and raddr == 0: rdata = 0, rbusy = 0.
  - Else if BYPASS=1 and we && ready && waddr == raddr: rdata = wdata, rbusy = 0.
  - Else: rdata = regs[raddr], rbusy = busy[raddr].
  - With BYPASS=0, a read returns the pre-write value in the write cycle and the new value from the next cycle.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clr_req = 1 at posedge; counter <= 0.
  - In SWEEP, each posedge: regs[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt + 1.
  - When cnt == DEPTH-1, that register is cleared and the FSM returns to IDLE. The sweep takes exactly DEPTH cycles.
  - clr_busy = (state == SWEEP); ready = 0 throughout the sweep.
  - During SWEEP: we and rsv_en are ignored (dropped, not queued; the source must hold them until ready = 1).
  - During SWEEP: clr_req is ignored.
  - During SWEEP: bypass is inactive and reads return the current array contents (partially cleared).
  - A clr_req in the cycle ready returns starts a new sweep.
- Reset mid-sweep: immediate full clear, FSM = IDLE.
- Counter width is ADDR_W and wraps naturally at DEPTH-1; no overflow is possible.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 with BYPASS=1, reading A = r5 in the same cycle -> rdata_a = 0xDEADBEEF combinationally; r5 holds it on later cycles; rbusy_a = 0.
2. ZERO_REG=1: write 0x12345678 to r0 and reserve r0 -> rdata_a(r0) = 0, rbusy_a = 0 always. With ZERO_REG=0, r0 reads 0x12345678.
3. Reserve r3 -> rbusy_b(r3) = 1 next cycle; write r3 = 0x55 -> rbusy_b = 0 and rdata_b = 0x55 in the write cycle (bypass). Same-cycle write and reserve of r3 -> rbusy = 1 afterwards, data = new value.
4. Fill r0..r15 with non-zero values and busy bits, then pulse clr_req -> clr_busy = 1 and ready = 0 for exactly 16 cycles; r7 reads 0 from the cycle after the 8th sweep edge; all registers 0 and all busy bits 0 at the end; ready = 1 on the 17th cycle.
5. Assert we to r9 = 0xAA during a sweep -> write dropped, r9 = 0 after the sweep. Assert rst at sweep cycle 5 -> all registers 0, clr_busy = 0 asynchronously.
6. BYPASS=0, DATA_W=16, ADDR_W=3: write r2 = 0xBEEF while reading r2 -> old value (0) in the write cycle, 0xBEEF next cycle; an 8-cycle sweep clears all registers.
